// File: rtl/fetch_stall_ctrl.sv
// fetch_stall_ctrl: owns the PC register and the IF/ID pipeline register.
// It applies the hazard unit's pc_write/ifid_write/hz_stall controls, EX
// redirects and ID HALT decode. It also drives the ID/EX bubble select and
// the halted status.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   pc_write_i         1 = PC may advance
//   ifid_write_i       1 = IF/ID may load
//   hz_stall_i         load-use stall request
//   redirect_i         taken branch/jump resolved in EX
//   redirect_pc_i      redirect target
//   imem_instr_i       instruction fetched at pc_o
//   id_halt_op_i       ID decoded a HALT
//   pc_o               current fetch address
//   ifid_instr_o       IF/ID instruction
//   ifid_pc_plus2_o    IF/ID captured pc+2
//   ifid_valid_o       IF/ID holds a real instruction
//   idex_bubble_o      select NOP controls into ID/EX this cycle
//   stopped_o          processor halted (sticky until reset)
//   stall_err_o        a stall run reached MAX_STALL (sticky until reset)
//   stall_cycles_o     total stall cycles; only counts when FETCH_STALL_PERF_EN
//                      is defined, otherwise tied to zero
//
// Optional feature macro: FETCH_STALL_PERF_EN (saturating stall-cycle counter).
module fetch_stall_ctrl #(
    parameter int unsigned          PC_W      = 16,
    parameter int unsigned          INSTR_W   = 16,
    parameter logic [PC_W-1:0]      RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = '0,
    parameter int unsigned          MAX_STALL = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_write_i,
    input  logic               ifid_write_i,
    input  logic               hz_stall_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    input  logic [INSTR_W-1:0] imem_instr_i,
    input  logic               id_halt_op_i,
    output logic [PC_W-1:0]    pc_o,
    output logic [INSTR_W-1:0] ifid_instr_o,
    output logic [PC_W-1:0]    ifid_pc_plus2_o,
    output logic               ifid_valid_o,
    output logic               idex_bubble_o,
    output logic               stopped_o,
    output logic               stall_err_o,
    output logic [15:0]        stall_cycles_o
);

    localparam logic [3:0] MaxStall = 4'(MAX_STALL);

    typedef enum logic [1:0] {StRun, StStall, StStop} state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [PC_W-1:0]    ifid_pc2_q, ifid_pc2_d;
    logic               ifid_valid_q, ifid_valid_d;
    logic               stopped_q, stopped_d;
    logic               stall_err_q, stall_err_d;
    logic [3:0]         run_cnt_q, run_cnt_d;
    logic [PC_W-1:0]    pc_plus2;
    logic               halt_take;
    logic               stall_live;

    assign pc_plus2   = pc_q + PC_W'(2);
    // A HALT alongside a redirect is on the wrong path and is flushed instead.
    assign halt_take  = id_halt_op_i & ifid_valid_q & ~redirect_i;
    assign stall_live = hz_stall_i & ~redirect_i;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc2_d   = ifid_pc2_q;
        ifid_valid_d = ifid_valid_q;
        stopped_d    = stopped_q;
        stall_err_d  = stall_err_q;
        run_cnt_d    = run_cnt_q;

        if (state_q != StStop) begin
            if (halt_take) begin
                // HALT freezes fetch on the same edge; nothing behind it enters ID.
                state_d      = StStop;
                stopped_d    = 1'b1;
                ifid_valid_d = 1'b0;
            end else begin
                state_d = stall_live ? StStall : StRun;

                if (redirect_i) begin
                    pc_d = redirect_pc_i;
                end else if (pc_write_i) begin
                    pc_d = pc_plus2;
                end

                if (redirect_i) begin
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                end else if (ifid_write_i) begin
                    ifid_instr_d = imem_instr_i;
                    ifid_pc2_d   = pc_plus2;
                    ifid_valid_d = 1'b1;
                end
            end

            if (stall_live) begin
                run_cnt_d = (run_cnt_q == MaxStall) ? run_cnt_q : run_cnt_q + 4'd1;
            end else begin
                run_cnt_d = '0;
            end
            stall_err_d = stall_err_q | (run_cnt_d == MaxStall);
        end else begin
            ifid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StRun;
            pc_q         <= RESET_PC;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc2_q   <= '0;
            ifid_valid_q <= 1'b0;
            stopped_q    <= 1'b0;
            stall_err_q  <= 1'b0;
            run_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc2_q   <= ifid_pc2_d;
            ifid_valid_q <= ifid_valid_d;
            stopped_q    <= stopped_d;
            stall_err_q  <= stall_err_d;
            run_cnt_q    <= run_cnt_d;
        end
    end

`ifdef FETCH_STALL_PERF_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if ((state_q != StStop) && hz_stall_i && (perf_q != 16'hFFFF)) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign stall_cycles_o = perf_q;
`else
    assign stall_cycles_o = '0;
`endif

    assign pc_o            = pc_q;
    assign ifid_instr_o    = ifid_instr_q;
    assign ifid_pc_plus2_o = ifid_pc2_q;
    assign ifid_valid_o    = ifid_valid_q;
    assign stopped_o       = stopped_q;
    assign stall_err_o     = stall_err_q;
    assign idex_bubble_o   = rst ? 1'b0
                           : ((state_q == StStop) | hz_stall_i | redirect_i | ~ifid_valid_q);

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Self-checking bench for fetch_stall_ctrl. Each scenario steps a table of
// inputs; expected register values are queued as stimulus is driven and
// popped after the following rising edge.
module tb_fetch_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_write = 1'b0, ifid_write = 1'b0, hz_stall = 1'b0;
    logic        redirect = 1'b0, id_halt_op = 1'b0;
    logic [15:0] redirect_pc = '0, imem_instr = '0;
    logic [15:0] pc, ifid_instr, ifid_pc_plus2, stall_cycles;
    logic        ifid_valid, idex_bubble, stopped, stall_err;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic        hz;
        logic        pw;
        logic        iw;
        logic        rd;
        logic [15:0] rpc;
        logic [15:0] instr;
        logic        halt;
        logic        bub;   // expected idex_bubble before the edge
    } stim_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] pc2;
        logic        valid;
        logic        stopped;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

`ifdef FETCH_STALL_PERF_EN
    localparam logic [15:0] PerfAfter3 = 16'd3;
`else
    localparam logic [15:0] PerfAfter3 = 16'd0;
`endif

    fetch_stall_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .pc_write_i     (pc_write),
        .ifid_write_i   (ifid_write),
        .hz_stall_i     (hz_stall),
        .redirect_i     (redirect),
        .redirect_pc_i  (redirect_pc),
        .imem_instr_i   (imem_instr),
        .id_halt_op_i   (id_halt_op),
        .pc_o           (pc),
        .ifid_instr_o   (ifid_instr),
        .ifid_pc_plus2_o(ifid_pc_plus2),
        .ifid_valid_o   (ifid_valid),
        .idex_bubble_o  (idex_bubble),
        .stopped_o      (stopped),
        .stall_err_o    (stall_err),
        .stall_cycles_o (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic drive(input stim_t s);
        hz_stall    = s.hz;
        pc_write    = s.pw;
        ifid_write  = s.iw;
        redirect    = s.rd;
        redirect_pc = s.rpc;
        imem_instr  = s.instr;
        id_halt_op  = s.halt;
    endtask

    function automatic exp_t observe();
        return '{pc, ifid_instr, ifid_pc_plus2, ifid_valid, stopped, stall_err};
    endfunction

    task automatic test_reset();
        exp_t got;
        @(posedge clk);
        #1;
        exp_q.push_back('{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0});
        got = observe();
        tests++;
        if (got !== exp_q[0]) begin
            fails++;
            $display("FAIL reset regs: got %h want %h", got, exp_q[0]);
        end
        void'(exp_q.pop_front());
        tests++;
        if (idex_bubble !== 1'b0) begin
            fails++;
            $display("FAIL reset bubble: got %b want 0", idex_bubble);
        end
        tests++;
        if (stall_cycles !== 16'h0000) begin
            fails++;
            $display("FAIL reset stall_cycles: got %h want 0000", stall_cycles);
        end
        rst = 1'b0;
    endtask

    task automatic test_advance();
        stim_t st[5];
        exp_t  ex[5];
        exp_t  got, want;
        st[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1234, 1'b0, 1'b1};
        ex[0] = '{16'h0002, 16'h1234, 16'h0002, 1'b1, 1'b0, 1'b0};
        st[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h5678, 1'b0, 1'b0};
        ex[1] = '{16'h0004, 16'h5678, 16'h0004, 1'b1, 1'b0, 1'b0};
        st[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h9ABC, 1'b0, 1'b0};
        ex[2] = '{16'h0006, 16'h9ABC, 16'h0006, 1'b1, 1'b0, 1'b0};
        st[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1111, 1'b0, 1'b1};
        ex[3] = '{16'h0006, 16'h9ABC, 16'h0006, 1'b1, 1'b0, 1'b0};
        st[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h2222, 1'b0, 1'b0};
        ex[4] = '{16'h0008, 16'h2222, 16'h0008, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            #1;
            tests++;
            if (idex_bubble !== st[i].bub) begin
                fails++;
                $display("FAIL advance bubble step %0d: got %b want %b", i, idex_bubble, st[i].bub);
            end
            @(posedge clk);
            #1;
            got  = observe();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL advance regs step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_redirect();
        stim_t st[6];
        exp_t  ex[6];
        exp_t  got, want;
        st[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
        ex[0] = '{16'h0008, 16'h2222, 16'h0008, 1'b1, 1'b0, 1'b0};
        st[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0040, 16'h0000, 1'b0, 1'b1};
        ex[1] = '{16'h0040, 16'h0000, 16'h0008, 1'b0, 1'b0, 1'b0};
        // Three more stall cycles: stall_err stays low only if the run was cleared.
        for (int i = 2; i < 5; i++) begin
            st[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
            ex[i] = '{16'h0040, 16'h0000, 16'h0008, 1'b0, 1'b0, 1'b0};
        end
        st[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hAAAA, 1'b0, 1'b1};
        ex[5] = '{16'h0042, 16'hAAAA, 16'h0042, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            #1;
            tests++;
            if (idex_bubble !== st[i].bub) begin
                fails++;
                $display("FAIL redirect bubble step %0d: got %b want %b", i, idex_bubble, st[i].bub);
            end
            @(posedge clk);
            #1;
            got  = observe();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL redirect regs step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_stall_err();
        stim_t st[6];
        exp_t  ex[6];
        exp_t  got, want;
        for (int i = 0; i < 4; i++) begin
            st[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
            ex[i] = '{16'h0042, 16'hAAAA, 16'h0042, 1'b1, 1'b0, (i == 3)};
        end
        st[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hBBBB, 1'b0, 1'b0};
        ex[4] = '{16'h0044, 16'hBBBB, 16'h0044, 1'b1, 1'b0, 1'b1};
        st[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hCCCC, 1'b0, 1'b0};
        ex[5] = '{16'h0046, 16'hCCCC, 16'h0046, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            #1;
            tests++;
            if (idex_bubble !== st[i].bub) begin
                fails++;
                $display("FAIL stall_err bubble step %0d: got %b want %b", i, idex_bubble, st[i].bub);
            end
            @(posedge clk);
            #1;
            got  = observe();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL stall_err regs step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_halt();
        stim_t st[6];
        exp_t  ex[6];
        exp_t  got, want;
        // HALT, then redirect/pc_write/stall while stopped, then idle.
        st[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hDDDD, 1'b1, 1'b0};
        st[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0100, 16'hEEEE, 1'b0, 1'b1};
        st[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) ex[i] = '{16'h0046, 16'hCCCC, 16'h0046, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            #1;
            tests++;
            if (idex_bubble !== st[i].bub) begin
                fails++;
                $display("FAIL halt bubble step %0d: got %b want %b", i, idex_bubble, st[i].bub);
            end
            @(posedge clk);
            #1;
            got  = observe();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL halt regs step %0d: got %h want %h", i, got, want);
            end
        end

        // Reset mid-cycle leaves STOP and clears the sticky flags at once.
        rst = 1'b1;
        #1;
        got = observe();
        tests++;
        if (got !== 51'h0) begin
            fails++;
            $display("FAIL halt async reset: got %h want %h", got, 51'h0);
        end
        drive('0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // HALT together with a redirect is discarded.
        st[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1234, 1'b0, 1'b1};
        ex[3] = '{16'h0002, 16'h1234, 16'h0002, 1'b1, 1'b0, 1'b0};
        st[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0080, 16'h4321, 1'b1, 1'b1};
        ex[4] = '{16'h0080, 16'h0000, 16'h0002, 1'b0, 1'b0, 1'b0};
        st[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h5555, 1'b0, 1'b1};
        ex[5] = '{16'h0082, 16'h5555, 16'h0082, 1'b1, 1'b0, 1'b0};
        for (int i = 3; i < 6; i++) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            #1;
            tests++;
            if (idex_bubble !== st[i].bub) begin
                fails++;
                $display("FAIL halt_redirect bubble step %0d: got %b want %b", i, idex_bubble, st[i].bub);
            end
            @(posedge clk);
            #1;
            got  = observe();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL halt_redirect regs step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_wrap_perf_reset();
        stim_t st[5];
        exp_t  ex[5];
        exp_t  got, want;
        st[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFE, 16'h0000, 1'b0, 1'b1};
        ex[0] = '{16'hFFFE, 16'h0000, 16'h0082, 1'b0, 1'b0, 1'b0};
        st[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h7777, 1'b0, 1'b1};
        ex[1] = '{16'h0000, 16'h7777, 16'h0000, 1'b1, 1'b0, 1'b0};
        for (int i = 2; i < 5; i++) begin
            st[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
            ex[i] = '{16'h0000, 16'h7777, 16'h0000, 1'b1, 1'b0, 1'b0};
        end
        for (int i = 0; i < 5; i++) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            #1;
            tests++;
            if (idex_bubble !== st[i].bub) begin
                fails++;
                $display("FAIL wrap bubble step %0d: got %b want %b", i, idex_bubble, st[i].bub);
            end
            @(posedge clk);
            #1;
            got  = observe();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL wrap regs step %0d: got %h want %h", i, got, want);
            end
        end
        tests++;
        if (stall_cycles !== PerfAfter3) begin
            fails++;
            $display("FAIL stall_cycles: got %h want %h", stall_cycles, PerfAfter3);
        end

        // Reset asserted mid-stall with hz_stall still high.
        drive(st[2]);
        #1;
        rst = 1'b1;
        #1;
        got = observe();
        tests++;
        if (got !== 51'h0) begin
            fails++;
            $display("FAIL midstall reset regs: got %h want %h", got, 51'h0);
        end
        tests++;
        if (idex_bubble !== 1'b0 || stall_cycles !== 16'h0000) begin
            fails++;
            $display("FAIL midstall reset bubble/cycles: got %b/%h want 0/0000",
                     idex_bubble, stall_cycles);
        end
        drive('0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_advance();
        test_redirect();
        test_stall_err();
        test_halt();
        test_wrap_perf_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
